keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad for the ATM coin machine, debounces presses, and queues one 4-bit key code per press in a small FIFO. The processor reads the FIFO through the data-memory read path. The block sits beside RAM in the top-level wrapper: the dmem address decode routes loads from the keypad address to `rdata`, and turns the load into a `pop` pulse. It drives the keypad columns and senses the keypad rows directly on FPGA pins.

---
 rtl/keypad_scanner.sv | 243 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, rejects
// multi-key (ghosting) scans, debounces press and release over whole scans,
// and queues one 4-bit key code per accepted press in a small FIFO that the
// processor drains through the data-memory read path.
//
// Ports
//   clock   system clock
//   reset   synchronous, active-high
//   rows_n  keypad rows, active-low, asynchronous to clock
//   col_n   keypad column drive, active-low, one-hot-low
//   pop     one-cycle dequeue strobe from the dmem decode
//   rdata   {26'b0, overflow, avail, code[3:0]}, combinational from registers
//   avail   FIFO not empty
module keypad_scanner #(
    parameter int SCAN_DIV       = 30000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rows_n,
    output logic [3:0]  col_n,
    input  logic        pop,
    output logic [31:0] rdata,
    output logic        avail
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW:0]      FULL_N   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    // ---- stage p0/p1: row synchronizer ----
    logic [3:0] rows_p0, rows_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rows_p0 <= 4'hF;
            rows_p1 <= 4'hF;
        end else begin
            rows_p0 <= rows_n;
            rows_p1 <= rows_p0;
        end
    end

    // Column sweep. SCAN_DIV >= 4 lets the synchronizer settle on the
    // current column before its last-cycle sample.
    logic [DIV_W-1:0] div;
    logic [1:0]       col;
    logic             sample;

    assign sample = (div == DIV_LAST);
    assign col_n  = ~(4'b0001 << col);

    always_ff @(posedge clock) begin
        if (reset) begin
            div <= '0;
            col <= 2'd0;
        end else if (sample) begin
            div <= '0;
            col <= col + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Per-column hit count (saturating at 2) and the row of the low bit.
    logic [3:0] low;
    logic [1:0] col_hits, col_row;
    logic [1:0] hits, tot_hits;
    logic [3:0] hit_code, tot_code;

    assign low = ~rows_p1;

    always_comb begin
        col_hits = 2'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (low[r]) begin
                col_row  = 2'(r);
                col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    // Running total over the scan; anything beyond one key collapses to 2.
    always_comb begin
        tot_hits = 2'd2;
        tot_code = hit_code;
        if (hits == 2'd0) begin
            tot_hits = col_hits;
            tot_code = {col_row, col};
        end else if (col_hits == 2'd0) begin
            tot_hits = hits;
        end
    end

    // ---- stage p2: completed scan result ----
    logic       scan_vld_p2;
    logic       scan_key_p2;
    logic [3:0] scan_code_p2;

    always_ff @(posedge clock) begin
        if (reset) begin
            hits        <= 2'd0;
            scan_vld_p2 <= 1'b0;
            scan_key_p2 <= 1'b0;
        end else begin
            scan_vld_p2 <= 1'b0;
            if (sample) begin
                if (col == 2'd3) begin
                    scan_vld_p2 <= 1'b1;
                    scan_key_p2 <= (tot_hits == 2'd1);
                    hits        <= 2'd0;
                end else begin
                    hits <= tot_hits;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sample) begin
            hit_code     <= tot_code;
            scan_code_p2 <= tot_code;
        end
    end

    // ---- stage p3: debounce FSM, one step per completed scan ----
    state_t           state;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             push_vld_p3;
    logic             same_key;

    assign cnt_inc  = cnt + CNT_ONE;
    assign same_key = scan_key_p2 && (scan_code_p2 == cand);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cand        <= 4'd0;
            cnt         <= '0;
            push_vld_p3 <= 1'b0;
        end else begin
            push_vld_p3 <= 1'b0;
            if (scan_vld_p2) begin
                case (state)
                    IDLE: begin
                        if (scan_key_p2) begin
                            cand <= scan_code_p2;
                            cnt  <= CNT_ONE;
                            if (DEBOUNCE_SCANS == 1) begin
                                push_vld_p3 <= 1'b1;
                                state       <= HELD;
                            end else begin
                                state <= PRESS;
                            end
                        end
                    end
                    PRESS: begin
                        if (!scan_key_p2) begin
                            state <= IDLE;
                        end else if (same_key) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DEB_N) begin
                                push_vld_p3 <= 1'b1;
                                state       <= HELD;
                            end
                        end else begin
                            cand <= scan_code_p2;
                            cnt  <= CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!same_key) begin
                            cnt   <= CNT_ONE;
                            state <= (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (!scan_key_p2) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DEB_N) state <= IDLE;
                        end else if (same_key) begin
                            state <= HELD;
                        end else begin
                            cnt <= CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ---- stage p4: key-code FIFO ----
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic          overflow;
    logic          empty, full, do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_N);
    // Pop is applied before push, so a pop frees room for a same-cycle push.
    assign do_pop  = pop && !empty;
    assign do_push = push_vld_p3 && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (pop)                     overflow <= 1'b0;
            else if (push_vld_p3 && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[tail] <= cand;
    end

    assign avail = !empty;
    assign rdata = {26'b0, overflow, avail, (empty ? 4'd0 : mem[head])};

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4.
// A behavioural keypad drives rows_n from the held-key mask and col_n.
// Expected load values are queued as stimulus is issued; a monitor compares
// rdata on every load (pop while avail) against the queue head.
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pop   = 1'b0;
    logic [15:0] keys  = 16'h0;
    logic [3:0]  rows_n;
    logic [3:0]  col_n;
    logic [31:0] rdata;
    logic        avail;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) rows_n[r] = 1'b0;
    end

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rows_n(rows_n),
        .col_n(col_n),
        .pop(pop),
        .rdata(rdata),
        .avail(avail)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every load that returns data is checked against the queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            #1;
            if (pop && avail) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_unexpected: got 0x%08h expected no data", rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        errors++;
                        $display("FAIL load_data: got 0x%08h expected 0x%08h", rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Returns at the negedge of the first cycle of a scan (column 0, div 0).
    task automatic align_scan();
        int n = 0;
        while (col_n != 4'b0111 && n < 64) begin @(negedge clock); n++; end
        while (col_n != 4'b1110 && n < 128) begin @(negedge clock); n++; end
        checks++;
        if (n >= 128) begin
            errors++;
            $display("FAIL align_scan: got col_n %b expected 1110 within 128 cycles", col_n);
        end
    endtask

    task automatic wait_avail(input string name, input int bound);
        int n = 0;
        while (!avail && n < bound) begin @(negedge clock); n++; end
        checks++;
        if (!avail) begin
            errors++;
            $display("FAIL %s: got avail 0 expected 1 within %0d cycles", name, bound);
        end
    endtask

    task automatic read_fifo();
        @(negedge clock);
        pop = 1'b1;
        @(negedge clock);
        pop = 1'b0;
    endtask

    task automatic expect_empty(input string name);
        check32({name, "_queue"}, 32'(exp_q.size()), 32'd0);
        check32({name, "_avail"}, {31'b0, avail}, 32'd0);
        check32({name, "_rdata"}, rdata, 32'd0);
    endtask

    task automatic press_release(input int code);
        align_scan();
        keys = 16'h0;
        keys[code] = 1'b1;
        repeat (64) @(negedge clock);
        keys = 16'h0;
        repeat (64) @(negedge clock);
    endtask

    initial begin
        logic [3:0] e;

        // Reset and sweep
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check32("reset_col_n", {28'b0, col_n}, 32'h0000000E);
        check32("reset_rdata", rdata, 32'h0);
        check32("reset_avail", {31'b0, avail}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            e = ~(4'b0001 << ((k / 4) % 4));
            check32("sweep_col_n", {28'b0, col_n}, {28'b0, e});
            @(negedge clock);
        end
        check32("sweep_rdata", rdata, 32'h0);

        // Single press of key 9 for 5 scans
        do_reset();
        align_scan();
        exp_q.push_back(32'h19);
        keys = 16'h0200;
        wait_avail("single_latency", 52);
        read_fifo();
        repeat (40) @(negedge clock);
        keys = 16'h0;
        repeat (64) @(negedge clock);
        expect_empty("single");

        // Bounce: key 9 on alternate scans
        do_reset();
        align_scan();
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (16) @(negedge clock);
        end
        check32("bounce_no_push", {31'b0, avail}, 32'h0);
        exp_q.push_back(32'h19);
        keys = 16'h0200;
        wait_avail("bounce_steady", 52);
        read_fifo();
        repeat (16) @(negedge clock);
        keys = 16'h0;
        repeat (64) @(negedge clock);
        expect_empty("bounce");

        // Ghosting: keys 0 and 5 together, then key 0 alone
        do_reset();
        align_scan();
        keys = 16'h0021;
        repeat (96) @(negedge clock);
        check32("ghost_no_push", {31'b0, avail}, 32'h0);
        exp_q.push_back(32'h10);
        keys = 16'h0001;
        wait_avail("ghost_release", 52);
        read_fifo();
        keys = 16'h0;
        repeat (64) @(negedge clock);
        expect_empty("ghost");

        // Overflow
        do_reset();
        press_release(3);
        press_release(6);
        press_release(9);
        press_release(12);
        check32("ovf_four_entries", rdata, 32'h13);
        press_release(15);
        check32("ovf_set", rdata, 32'h33);
        exp_q.push_back(32'h33);
        read_fifo();
        check32("ovf_clear_on_pop", rdata, 32'h16);
        press_release(14);
        check32("ovf_full_again", rdata, 32'h16);
        // Press key 7 and pop on the very edge its code is written.
        exp_q.push_back(32'h16);
        align_scan();
        keys = 16'h0080;
        repeat (33) @(negedge clock);
        pop = 1'b1;
        @(negedge clock);
        pop = 1'b0;
        repeat (30) @(negedge clock);
        keys = 16'h0;
        repeat (64) @(negedge clock);
        check32("ovf_push_pop_full", rdata, 32'h19);
        exp_q.push_back(32'h19);
        exp_q.push_back(32'h1C);
        exp_q.push_back(32'h1E);
        exp_q.push_back(32'h17);
        repeat (4) read_fifo();
        expect_empty("ovf_drain");

        // Reset mid-press with key 9 held
        do_reset();
        align_scan();
        keys = 16'h0200;
        repeat (48) @(negedge clock);
        check32("midpress_pushed", rdata, 32'h19);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check32("midpress_reset_avail", {31'b0, avail}, 32'h0);
        check32("midpress_reset_rdata", rdata, 32'h0);
        reset = 1'b0;
        exp_q.push_back(32'h19);
        wait_avail("midpress_reaccept", 52);
        read_fifo();
        keys = 16'h0;
        repeat (64) @(negedge clock);
        expect_empty("midpress");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
